// File: rtl/butterfly_pkg.sv
// Shared state type, default widths and fixed-point helpers for the DIF butterfly.
package butterfly_pkg;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  localparam int N_DEF  = 32;
  localparam int D_DEF  = 16;
  localparam int WIDE_W = 128;

  typedef logic signed [WIDE_W-1:0] wide_t;

  // Callers narrow the result to n bits, which leaves product bits [n+d-1:d] (floor, no rounding).
  function automatic wide_t fx_slice(input wide_t p, input int frac);
    return p >>> frac;
  endfunction

endpackage

// File: rtl/butterfly_dif_if.sv
// Stream handshake and complex operand/result bus of the DIF butterfly.
interface butterfly_dif_if
  import butterfly_pkg::*;
#(
  parameter int n = N_DEF
);
  logic         recv_val, recv_rdy;
  logic         send_val, send_rdy;
  logic [n-1:0] ar, ac, br, bc, wr, wc;
  logic [n-1:0] cr, cc, dr, dc;

  modport master (
    output recv_val, ar, ac, br, bc, wr, wc, send_rdy,
    input  recv_rdy, send_val, cr, cc, dr, dc
  );

  modport slave (
    input  recv_val, ar, ac, br, bc, wr, wc, send_rdy,
    output recv_rdy, send_val, cr, cc, dr, dc
  );
endinterface

// File: rtl/butterfly_dif_cmul_iter_shift.sv
// Iterative shift-add complex multiplier: one multiplier bit per cycle, four real products in parallel.
module cmul_iter_shift
  import butterfly_pkg::*;
#(
  parameter int n = N_DEF,
  parameter int d = D_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [n-1:0] xr,
  input  logic [n-1:0] xc,
  input  logic [n-1:0] wr,
  input  logic [n-1:0] wc,
  output logic         done,
  output logic [n-1:0] pr,
  output logic [n-1:0] pc
);
  localparam int CW = $clog2(n);

  logic [CW-1:0]         cnt;
  logic                  busy;
  logic                  last;
  logic signed [2*n-1:0] mc_r, mc_c;
  logic signed [2*n-1:0] acc_rr, acc_cc, acc_rc, acc_cr;
  logic [n-1:0]          mp_r, mp_c;

  assign last = (cnt == CW'(n-1));

  // The multiplier sign bit carries weight -2^(n-1), so the last step subtracts.
  function automatic logic signed [2*n-1:0] step(input logic signed [2*n-1:0] acc,
                                                 input logic signed [2*n-1:0] mc,
                                                 input logic bit_set, input logic neg);
    if (!bit_set) return acc;
    return neg ? acc - mc : acc + mc;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      mc_r   <= '0;
      mc_c   <= '0;
      mp_r   <= '0;
      mp_c   <= '0;
      acc_rr <= '0;
      acc_cc <= '0;
      acc_rc <= '0;
      acc_cr <= '0;
    end else if (start) begin
      cnt    <= '0;
      busy   <= 1'b1;
      done   <= 1'b0;
      mc_r   <= {{n{xr[n-1]}}, xr};
      mc_c   <= {{n{xc[n-1]}}, xc};
      mp_r   <= wr;
      mp_c   <= wc;
      acc_rr <= '0;
      acc_cc <= '0;
      acc_rc <= '0;
      acc_cr <= '0;
    end else if (busy) begin
      acc_rr <= step(acc_rr, mc_r, mp_r[0], last);
      acc_cc <= step(acc_cc, mc_c, mp_c[0], last);
      acc_rc <= step(acc_rc, mc_r, mp_c[0], last);
      acc_cr <= step(acc_cr, mc_c, mp_r[0], last);
      mc_r   <= mc_r <<< 1;
      mc_c   <= mc_c <<< 1;
      mp_r   <= mp_r >> 1;
      mp_c   <= mp_c >> 1;
      if (last) begin
        busy <= 1'b0;
        done <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      done <= 1'b0;
    end
  end

  assign pr = n'(fx_slice(wide_t'(acc_rr), d)) - n'(fx_slice(wide_t'(acc_cc), d));
  assign pc = n'(fx_slice(wide_t'(acc_rc), d)) + n'(fx_slice(wide_t'(acc_cr), d));

endmodule

// File: rtl/butterfly_dif.sv
// Radix-2 DIF butterfly: c = a + b, d = (a - b) * w, with optional 1/2 scaling and twiddle bypass.
module butterfly_dif
  import butterfly_pkg::*;
#(
  parameter int n     = N_DEF,
  parameter int d     = D_DEF,
  parameter bit mult  = 1'b1,
  parameter bit scale = 1'b0
) (
  input  logic           clk,
  input  logic           reset,
  butterfly_dif_if.slave bus
);
  state_t              state, state_next;
  logic                accept;
  logic signed [n:0]   sr_full, sc_full, xr_full, xc_full;
  logic [n-1:0]        sr_next, sc_next, xr_next, xc_next;
  logic [n-1:0]        cr_q, cc_q, dr_q, dc_q;
  logic                mul_done;
  logic [n-1:0]        mul_pr, mul_pc;

  // One extra bit keeps the carry so the optional halving sees the true sum.
  assign sr_full = {bus.ar[n-1], bus.ar} + {bus.br[n-1], bus.br};
  assign sc_full = {bus.ac[n-1], bus.ac} + {bus.bc[n-1], bus.bc};
  assign xr_full = {bus.ar[n-1], bus.ar} - {bus.br[n-1], bus.br};
  assign xc_full = {bus.ac[n-1], bus.ac} - {bus.bc[n-1], bus.bc};

  assign sr_next = n'(scale ? (sr_full >>> 1) : sr_full);
  assign sc_next = n'(scale ? (sc_full >>> 1) : sc_full);
  assign xr_next = n'(scale ? (xr_full >>> 1) : xr_full);
  assign xc_next = n'(scale ? (xc_full >>> 1) : xc_full);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next   = state;
    accept       = 1'b0;
    bus.recv_rdy = 1'b0;
    bus.send_val = 1'b0;
    case (state)
      IDLE: begin
        bus.recv_rdy = 1'b1;
        if (bus.recv_val) begin
          accept     = 1'b1;
          state_next = mult ? MUL : DONE;
        end
      end
      MUL: begin
        if (mul_done) state_next = DONE;
      end
      DONE: begin
        bus.send_val = 1'b1;
        if (bus.send_rdy) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cr_q <= '0;
      cc_q <= '0;
      dr_q <= '0;
      dc_q <= '0;
    end else if (accept) begin
      cr_q <= sr_next;
      cc_q <= sc_next;
      if (!mult) begin
        dr_q <= xr_next;
        dc_q <= xc_next;
      end
    end else if (state == MUL && mul_done) begin
      dr_q <= mul_pr;
      dc_q <= mul_pc;
    end
  end

  assign bus.cr = cr_q;
  assign bus.cc = cc_q;
  assign bus.dr = dr_q;
  assign bus.dc = dc_q;

  if (mult) begin : g_mul
    cmul_iter_shift #(.n(n), .d(d)) u_cmul (
      .clk   (clk),
      .reset (reset),
      .start (accept),
      .xr    (xr_next),
      .xc    (xc_next),
      .wr    (bus.wr),
      .wc    (bus.wc),
      .done  (mul_done),
      .pr    (mul_pr),
      .pc    (mul_pc)
    );
  end else begin : g_bypass
    assign mul_done = 1'b0;
    assign mul_pr   = '0;
    assign mul_pc   = '0;
  end

endmodule

// File: tb/tb_butterfly_dif.sv
// Bench driving three butterfly configurations (plain, scaled, bypass) with identical operand vectors.
module tb_butterfly_dif;

  logic        clk = 1'b0;
  logic        reset;
  logic        recv_val, send_rdy;
  logic [31:0] ar, ac, br, bc, wr, wc;
  logic [2:0]  recv_rdy_o, send_val_o;
  logic [31:0] cr_o[3], cc_o[3], dr_o[3], dc_o[3];

  int tests_run = 0;
  int tests_failed = 0;
  int lat_exp[3] = '{33, 33, 1};

  always #5 clk = ~clk;

  butterfly_dif_if #(.n(32)) bus[3] ();

  for (genvar g = 0; g < 3; g++) begin : g_wire
    assign bus[g].recv_val = recv_val;
    assign bus[g].send_rdy = send_rdy;
    assign bus[g].ar = ar;
    assign bus[g].ac = ac;
    assign bus[g].br = br;
    assign bus[g].bc = bc;
    assign bus[g].wr = wr;
    assign bus[g].wc = wc;
    assign recv_rdy_o[g] = bus[g].recv_rdy;
    assign send_val_o[g] = bus[g].send_val;
    assign cr_o[g] = bus[g].cr;
    assign cc_o[g] = bus[g].cc;
    assign dr_o[g] = bus[g].dr;
    assign dc_o[g] = bus[g].dc;
  end

  butterfly_dif #(.n(32), .d(16), .mult(1'b1), .scale(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(bus[0]));
  butterfly_dif #(.n(32), .d(16), .mult(1'b1), .scale(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(bus[1]));
  butterfly_dif #(.n(32), .d(16), .mult(1'b0), .scale(1'b0)) dut2 (.clk(clk), .reset(reset), .bus(bus[2]));

  typedef struct {
    logic [31:0]      a_r, a_c, b_r, b_c, w_r, w_c;
    logic [2:0][31:0] e_cr, e_cc, e_dr, e_dc;
  } vec_t;

  vec_t vecs[7];

  task automatic add_vec(input int i, input logic [31:0] a_r, a_c, b_r, b_c, w_r, w_c);
    vecs[i].a_r = a_r; vecs[i].a_c = a_c;
    vecs[i].b_r = b_r; vecs[i].b_c = b_c;
    vecs[i].w_r = w_r; vecs[i].w_c = w_c;
  endtask

  task automatic add_exp(input int i, input int cfg, input logic [31:0] c_r, c_c, d_r, d_c);
    vecs[i].e_cr[cfg] = c_r; vecs[i].e_cc[cfg] = c_c;
    vecs[i].e_dr[cfg] = d_r; vecs[i].e_dc[cfg] = d_c;
  endtask

  task automatic check_output(input string name, input int cfg, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s cfg%0d: got 0x%08h, want 0x%08h", name, cfg, act, exp);
    end
  endtask

  // Presents vector i for one accept edge and measures, per config, the edges until send_val.
  task automatic apply_stimulus(input int i, output int lat[3]);
    @(negedge clk);
    check_output($sformatf("v%0d_idle_rdy", i), 9, 32'(recv_rdy_o), 32'h7);
    ar = vecs[i].a_r; ac = vecs[i].a_c;
    br = vecs[i].b_r; bc = vecs[i].b_c;
    wr = vecs[i].w_r; wc = vecs[i].w_c;
    recv_val = 1'b1;
    @(posedge clk);
    #1 recv_val = 1'b0;
    lat = '{0, 0, 0};
    for (int k = 1; k <= 60 && (lat[0] == 0 || lat[1] == 0 || lat[2] == 0); k++) begin
      @(posedge clk);
      #1;
      for (int g = 0; g < 3; g++)
        if (send_val_o[g] && lat[g] == 0) lat[g] = k;
    end
  endtask

  task automatic check_results(input int i);
    for (int g = 0; g < 3; g++) begin
      check_output($sformatf("v%0d_cr", i), g, cr_o[g], vecs[i].e_cr[g]);
      check_output($sformatf("v%0d_cc", i), g, cc_o[g], vecs[i].e_cc[g]);
      check_output($sformatf("v%0d_dr", i), g, dr_o[g], vecs[i].e_dr[g]);
      check_output($sformatf("v%0d_dc", i), g, dc_o[g], vecs[i].e_dc[g]);
    end
  endtask

  task automatic release_results(input string name);
    @(negedge clk);
    send_rdy = 1'b1;
    @(posedge clk);
    #1;
    check_output({name, "_rdy_after_send"}, 9, 32'(recv_rdy_o), 32'h7);
    check_output({name, "_val_after_send"}, 9, 32'(send_val_o), 32'h0);
    @(negedge clk);
    send_rdy = 1'b0;
  endtask

  task automatic run_vector(input int i);
    int lat[3];
    apply_stimulus(i, lat);
    for (int g = 0; g < 3; g++)
      check_output($sformatf("v%0d_latency", i), g, 32'(lat[g]), 32'(lat_exp[g]));
    check_results(i);
    release_results($sformatf("v%0d", i));
  endtask

  initial begin
    int lat[3];

    // Expected values per config: 0 = plain multiply, 1 = halved, 2 = twiddle bypass.
    add_vec(0, 32'h00010000, 32'h0, 32'h00008000, 32'h0, 32'h0, 32'h00010000);
    add_exp(0, 0, 32'h00018000, 32'h0, 32'h0, 32'h00008000);
    add_exp(0, 1, 32'h0000C000, 32'h0, 32'h0, 32'h00004000);
    add_exp(0, 2, 32'h00018000, 32'h0, 32'h00008000, 32'h0);

    add_vec(1, 32'h0, 32'h0, 32'h00010000, 32'h0, 32'h00010000, 32'h0);
    add_exp(1, 0, 32'h00010000, 32'h0, 32'hFFFF0000, 32'h0);
    add_exp(1, 1, 32'h00008000, 32'h0, 32'hFFFF8000, 32'h0);
    add_exp(1, 2, 32'h00010000, 32'h0, 32'hFFFF0000, 32'h0);

    add_vec(2, 32'h00020000, 32'h00020000, 32'h0, 32'h0, 32'h00010000, 32'h0);
    add_exp(2, 0, 32'h00020000, 32'h00020000, 32'h00020000, 32'h00020000);
    add_exp(2, 1, 32'h00010000, 32'h00010000, 32'h00010000, 32'h00010000);
    add_exp(2, 2, 32'h00020000, 32'h00020000, 32'h00020000, 32'h00020000);

    add_vec(3, 32'd3, 32'd4, 32'd1, 32'd1, 32'h00010000, 32'h0);
    add_exp(3, 0, 32'd4, 32'd5, 32'd2, 32'd3);
    add_exp(3, 1, 32'd2, 32'd2, 32'd1, 32'd1);
    add_exp(3, 2, 32'd4, 32'd5, 32'd2, 32'd3);

    add_vec(4, 32'h00010000, 32'h00020000, 32'h00030000, 32'h0, 32'h0, 32'hFFFF0000);
    add_exp(4, 0, 32'h00040000, 32'h00020000, 32'h00020000, 32'h00020000);
    add_exp(4, 1, 32'h00020000, 32'h00010000, 32'h00010000, 32'h00010000);
    add_exp(4, 2, 32'h00040000, 32'h00020000, 32'hFFFE0000, 32'h00020000);

    add_vec(5, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0, 32'h00008000, 32'h0);
    for (int g = 0; g < 3; g++) add_exp(5, g, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 32'h0);

    add_vec(6, 32'h7FFFFFFF, 32'h80000000, 32'h00000001, 32'h80000000, 32'h0, 32'h0);
    add_exp(6, 0, 32'h80000000, 32'h0, 32'h0, 32'h0);
    add_exp(6, 1, 32'h40000000, 32'h80000000, 32'h0, 32'h0);
    add_exp(6, 2, 32'h80000000, 32'h0, 32'h7FFFFFFE, 32'h0);

    reset = 1'b0;
    recv_val = 1'b0;
    send_rdy = 1'b0;
    {ar, ac, br, bc, wr, wc} = '0;
    #1;
    check_output("reset_rdy", 9, 32'(recv_rdy_o), 32'h7);
    check_output("reset_val", 9, 32'(send_val_o), 32'h0);
    check_output("reset_cr", 0, cr_o[0], 32'h0);
    check_output("reset_dr", 0, dr_o[0], 32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 7; i++) run_vector(i);

    // Backpressure: results must hold and new operands must be ignored while send_rdy is low.
    apply_stimulus(2, lat);
    check_results(2);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      recv_val = 1'b1;
      ar = 32'h12345678 + k; ac = 32'h0BADF00D;
      br = 32'h00000100;     bc = 32'h00000200;
      @(posedge clk);
      #1;
      check_output("stall_rdy", 9, 32'(recv_rdy_o), 32'h0);
      check_output("stall_val", 9, 32'(send_val_o), 32'h7);
      check_output("stall_dr", 0, dr_o[0], vecs[2].e_dr[0]);
    end
    @(negedge clk);
    recv_val = 1'b0;
    send_rdy = 1'b1;
    @(posedge clk);
    #1;
    check_output("stall_release_rdy", 9, 32'(recv_rdy_o), 32'h7);
    check_output("stall_kept_cr", 0, cr_o[0], vecs[2].e_cr[0]);
    check_output("stall_kept_cr", 2, cr_o[2], vecs[2].e_cr[2]);
    @(negedge clk);
    send_rdy = 1'b0;

    // Asynchronous reset while the multiplier counter sits at 10.
    @(negedge clk);
    ar = vecs[4].a_r; ac = vecs[4].a_c;
    br = vecs[4].b_r; bc = vecs[4].b_c;
    wr = vecs[4].w_r; wc = vecs[4].w_c;
    recv_val = 1'b1;
    @(posedge clk);
    #1 recv_val = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    check_output("mid_mul_rdy", 0, 32'(recv_rdy_o[0]), 32'h0);
    check_output("mid_mul_cr", 0, cr_o[0], vecs[4].e_cr[0]);
    reset = 1'b0;
    #1;
    check_output("async_rst_rdy", 9, 32'(recv_rdy_o), 32'h7);
    check_output("async_rst_val", 9, 32'(send_val_o), 32'h0);
    check_output("async_rst_cr", 0, cr_o[0], 32'h0);
    check_output("async_rst_cc", 0, cc_o[0], 32'h0);
    check_output("async_rst_dr", 0, dr_o[0], 32'h0);
    check_output("async_rst_dc", 0, dc_o[0], 32'h0);
    check_output("async_rst_dr", 2, dr_o[2], 32'h0);
    @(negedge clk);
    reset = 1'b1;
    run_vector(4);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
